// File: rtl/cim_sched.sv
// rtl/cim_sched.sv - CIM_Unit control scheduler: STD-port weight load/readback FSM and compute issue pipe
`timescale 1ns/1ps
module cim_sched #(
  parameter int NUM_CORE = 8,
  parameter int ROWS     = 64,
  parameter int CIM_LAT  = 2,
  parameter int RD_LAT   = 1,
  localparam int CORE_W  = $clog2(NUM_CORE),
  localparam int ROW_W   = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wl_start,
  input  logic [CORE_W-1:0]   wl_core,
  output logic                start_ready,
  input  logic                wl_valid,
  output logic                wl_ready,
  input  logic                rd_req,
  input  logic [CORE_W-1:0]   rd_core,
  input  logic [ROW_W-1:0]    rd_row,
  output logic                rd_ready,
  output logic                rd_done,
  input  logic                cmp_valid,
  input  logic [CORE_W-1:0]   cmp_core,
  output logic                cmp_ready,
  output logic                cmp_err,
  output logic                psum_valid,
  output logic                STDW,
  output logic                STDR,
  output logic [CORE_W-1:0]   STD_Core_A,
  output logic [ROW_W-1:0]    STD_row_A,
  output logic                CIM_en,
  output logic [CORE_W-1:0]   CIM_Core_A,
  output logic [NUM_CORE-1:0] core_loaded
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t              state, state_nxt;
  logic                init_done;
  logic [ROW_W-1:0]    row_cnt;
  logic [RD_LAT-1:0]   rd_pipe;
  logic [CIM_LAT-1:0]  psum_pipe;
  logic                wl_acc, rd_acc, cmp_acc, last_row;

  // init_done keeps the handshake outputs low while reset is asserted
  assign start_ready = init_done && (state == IDLE);
  assign rd_ready    = start_ready && !wl_start;
  assign wl_ready    = (state == WRITE);
  assign STDW        = wl_ready && wl_valid;
  assign STDR        = (state == READ);
  assign STD_row_A   = row_cnt;
  assign cmp_ready   = init_done && !(wl_ready && (cmp_core == STD_Core_A));
  assign rd_done     = rd_pipe[RD_LAT-1];
  assign psum_valid  = psum_pipe[CIM_LAT-1];

  assign wl_acc   = start_ready && wl_start;
  assign rd_acc   = rd_ready && rd_req;
  assign cmp_acc  = cmp_valid && cmp_ready;
  assign last_row = (row_cnt == ROW_W'(ROWS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wl_acc)      state_nxt = WRITE;
        else if (rd_acc) state_nxt = READ;
      end
      WRITE:   if (STDW && last_row) state_nxt = IDLE;
      READ:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      init_done   <= 1'b0;
      STD_Core_A  <= '0;
      row_cnt     <= '0;
      core_loaded <= '0;
    end else begin
      state     <= state_nxt;
      init_done <= 1'b1;
      if (wl_acc) begin
        STD_Core_A           <= wl_core;
        row_cnt              <= '0;
        core_loaded[wl_core] <= 1'b0;
      end else if (rd_acc) begin
        STD_Core_A <= rd_core;
        row_cnt    <= rd_row;
      end else if (STDW) begin
        row_cnt <= row_cnt + 1'b1;
        if (last_row) core_loaded[STD_Core_A] <= 1'b1;
      end
    end
  end

  // Compute issue runs independently of the STD FSM; one issue per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CIM_en     <= 1'b0;
      CIM_Core_A <= '0;
      cmp_err    <= 1'b0;
      psum_pipe  <= '0;
      rd_pipe    <= '0;
    end else begin
      CIM_en  <= cmp_acc && core_loaded[cmp_core];
      cmp_err <= cmp_acc && !core_loaded[cmp_core];
      if (cmp_acc && core_loaded[cmp_core]) CIM_Core_A <= cmp_core;
      psum_pipe[0] <= CIM_en;
      for (int i = 1; i < CIM_LAT; i++) psum_pipe[i] <= psum_pipe[i-1];
      rd_pipe[0] <= STDR;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

endmodule
